mips_mem_subsystem: RTL and testbench
=====================================

# mips_mem_subsystem

Memory-side responder for the single-cycle MIPS core. It serves instruction fetch and data load/store on the core's bus: Pc/Instr, ALU_out/mem_write/Write_Data/Read_Data. It also contains a byte-serial boot loader that fills instruction memory after reset and holds the core in reset until loading completes.

## Interface
Parameters:
- IMEM_WORDS, 64, instruction memory depth in 32-bit words (power of two, ≤ 65535)
- DMEM_WORDS, 64, data memory depth in 32-bit words (power of two)

Ports (one clock; reset is asynchronous and active-high):
- CLK  input  1  system clock, all state on rising edge
- Reset  input  1  asynchronous, active-high reset
- Pc  input  32  core fetch address (byte address)
- Instr  output  32  fetched instruction, combinational
- ALU_out  input  32  core data byte address
- mem_write  input  1  core store strobe
- Write_Data  input  32  core store data
- Read_Data  output  32  load data, combinational
- ld_valid  input  1  loader byte valid
- ld_byte  input  8  loader byte
- ld_ready  output  1  loader byte accepted when ld_valid && ld_ready
- cpu_reset  output  1  drives core Reset; high until load completes
- load_done  output  1  high in RUN
- load_error  output  1  high in ERROR
- misalign_err  output  1  sticky; store to non-word-aligned address seen

## Operation
- Loader stream: 2-byte big-endian word count N, then N words, 4 bytes each, big-endian (MSB first).
- FSM states: CNT_HI -> CNT_LO -> (N==0 ? RUN : N>IMEM_WORDS ? ERROR : WORD) ; WORD -> RUN after 4·N bytes ; RUN, ERROR terminal until Reset.
- ld_ready = 1 in CNT_HI, CNT_LO, WORD; 0 in RUN, ERROR.
- WORD: bytes shifted into 24-bit assembler; on 4th accepted byte, {assembler, ld_byte} written to imem[idx], idx increments. idx wraps never; terminates at N.
- Register loaded_cnt = N on entry to RUN; reset value 0.
- Instr = imem[Pc[..:2]] when cpu_reset==0 and Pc[..:2] < loaded_cnt, else 32'h0 (sll nop). Pc[1:0] ignored.
- Read_Data = dmem[ALU_out[..:2]] when word index < DMEM_WORDS, else 32'h0. ALU_out[1:0] ignored on reads.
- Store: dmem written on rising edge when mem_write && !cpu_reset && ALU_out[1:0]==0 && index in range. Misaligned store: no write, misalign_err set. Out-of-range aligned store: silently dropped.
- Memory arrays are not reset; dmem content is undefined until written.

## Timing
- Reset values: state=CNT_HI, ld_ready=1, cpu_reset=1, load_done=0, load_error=0, misalign_err=0, loaded_cnt=0, idx=0. Instr=0 under reset.
- cpu_reset is registered: falls on the edge where the final byte (or CNT_LO with N==0) is accepted; core's first fetch at Pc=0 sees imem[0] that same cycle.
- Load latency: 2 + 4·N accepted bytes; ld_valid gaps stall without state loss.
- Store-to-load: Read_Data shows the new word in the cycle after the write edge (combinational read of registered array).
- Reset mid-load: immediate return to CNT_HI, loaded_cnt=0, so stale imem is never fetched.
- Simultaneous mem_write and cpu_reset=1: write suppressed.

## Structure
- Package mips_mem_pkg: loader state enum (CNT_HI, CNT_LO, WORD, RUN, ERROR), WORD_W=32, BYTES_PER_WORD=4, NOP_INSTR=32'h0.
- Sub-module mips_boot_loader: FSM, count/idx counters, byte assembler, imem write port, cpu_reset/load flags. Arrays and the core-facing read/store logic stay in mips_mem_subsystem.

## Test plan
- Load N=2: bytes 00 02 20 08 00 05 AC 08 00 04 -> imem[0]=32'h20080005, imem[1]=32'hAC080004; cpu_reset falls after 10th byte; Instr at Pc=8 = 0.
- N=0: bytes 00 00 -> RUN after 2nd byte, load_done=1, Instr=0 for all Pc.
- N=65 with IMEM_WORDS=64 -> ERROR after CNT_LO, load_error=1, ld_ready=0, cpu_reset stays 1.
- RUN: store 32'hDEADBEEF to ALU_out=0x10 -> Read_Data at 0x10 = 32'hDEADBEEF next cycle; store to 0x12 -> no write, misalign_err=1 and stays set.
- Reset asserted after 5 loader bytes with ld_valid gaps -> all outputs at reset values, Instr=0; reload of N=1 word succeeds.
- Store with mem_write=1 during load -> dmem unchanged (verified by later read in RUN).

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS memory subsystem and its boot loader.
package mips_mem_pkg;

    typedef enum logic [2:0] {
        CNT_HI,
        CNT_LO,
        WORD,
        RUN,
        ERROR
    } ldState_e;

    localparam int          WORD_W         = 32;
    localparam int          BYTES_PER_WORD = 4;
    localparam logic [31:0] NOP_INSTR      = 32'h0;

endpackage

// File: rtl/mips_boot_loader.sv
// Byte-serial boot loader: big-endian word count, then big-endian words into imem.
// Holds the core in reset until every announced word has been written.
module mips_boot_loader
    import mips_mem_pkg::*;
#(
    parameter  int IMEM_WORDS = 64,
    localparam int IMEM_AW    = $clog2(IMEM_WORDS)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               ldValid_i,
    input  logic [7:0]         ldByte_i,
    output logic               ldReady_o,
    output logic               cpuReset_o,
    output logic               loadDone_o,
    output logic               loadError_o,
    output logic [15:0]        loadedCnt_o,
    output logic               imemWe_o,
    output logic [IMEM_AW-1:0] imemAddr_o,
    output logic [WORD_W-1:0]  imemData_o
);

    localparam logic [15:0] IMEM_LIMIT = 16'(IMEM_WORDS);

    ldState_e    state_q, state_d;
    logic [15:0] wordCnt_q, wordCnt_d;
    logic [15:0] idx_q, idx_d;
    logic [23:0] asm_q, asm_d;
    logic [1:0]  bytePos_q, bytePos_d;
    logic [15:0] loadedCnt_q, loadedCnt_d;

    logic        inLoad;
    logic        accept;
    logic        lastByte;
    logic        lastWord;
    logic [15:0] countFull;

    assign inLoad    = (state_q == CNT_HI) || (state_q == CNT_LO) || (state_q == WORD);
    assign accept    = ldValid_i && inLoad;
    assign lastByte  = (bytePos_q == 2'(BYTES_PER_WORD - 1));
    assign lastWord  = ((idx_q + 16'd1) == wordCnt_q);
    assign countFull = {wordCnt_q[15:8], ldByte_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= CNT_HI;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CNT_HI: if (accept) state_d = CNT_LO;
            CNT_LO: begin
                if (accept) begin
                    if (countFull == 16'd0) begin
                        state_d = RUN;
                    end else if (countFull > IMEM_LIMIT) begin
                        state_d = ERROR;
                    end else begin
                        state_d = WORD;
                    end
                end
            end
            WORD:    if (accept && lastByte && lastWord) state_d = RUN;
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        ldReady_o   = inLoad;
        cpuReset_o  = (state_q != RUN);
        loadDone_o  = (state_q == RUN);
        loadError_o = (state_q == ERROR);
        loadedCnt_o = loadedCnt_q;
        imemWe_o    = accept && (state_q == WORD) && lastByte;
        imemAddr_o  = idx_q[IMEM_AW-1:0];
        imemData_o  = {asm_q, ldByte_i};
    end

    // The high count byte is parked in wordCnt_q[15:8] until the low byte arrives.
    always_comb begin
        wordCnt_d   = wordCnt_q;
        idx_d       = idx_q;
        asm_d       = asm_q;
        bytePos_d   = bytePos_q;
        loadedCnt_d = loadedCnt_q;
        if (accept) begin
            case (state_q)
                CNT_HI: wordCnt_d = {ldByte_i, 8'h00};
                CNT_LO: wordCnt_d = countFull;
                WORD: begin
                    if (lastByte) begin
                        bytePos_d = 2'd0;
                        idx_d     = idx_q + 16'd1;
                        if (lastWord) begin
                            loadedCnt_d = wordCnt_q;
                        end
                    end else begin
                        asm_d     = {asm_q[15:0], ldByte_i};
                        bytePos_d = bytePos_q + 2'd1;
                    end
                end
                default: wordCnt_d = wordCnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wordCnt_q   <= '0;
            idx_q       <= '0;
            asm_q       <= '0;
            bytePos_q   <= '0;
            loadedCnt_q <= '0;
        end else begin
            wordCnt_q   <= wordCnt_d;
            idx_q       <= idx_d;
            asm_q       <= asm_d;
            bytePos_q   <= bytePos_d;
            loadedCnt_q <= loadedCnt_d;
        end
    end

endmodule

// File: rtl/mips_mem_subsystem.sv
// Instruction and data memories for the single-cycle MIPS core, plus the boot loader
// that fills imem and releases the core from reset.
module mips_mem_subsystem
    import mips_mem_pkg::*;
#(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 64
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] Pc,
    output logic [31:0] Instr,
    input  logic [31:0] ALU_out,
    input  logic        mem_write,
    input  logic [31:0] Write_Data,
    output logic [31:0] Read_Data,
    input  logic        ld_valid,
    input  logic [7:0]  ld_byte,
    output logic        ld_ready,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        load_error,
    output logic        misalign_err
);

    localparam int IA = $clog2(IMEM_WORDS);
    localparam int DA = $clog2(DMEM_WORDS);

    logic [WORD_W-1:0] imem [IMEM_WORDS];
    logic [WORD_W-1:0] dmem [DMEM_WORDS];

    logic              imemWe;
    logic [IA-1:0]     imemAddr;
    logic [WORD_W-1:0] imemData;
    logic [15:0]       loadedCnt;
    logic              cpuReset;

    logic [29:0]       pcIdx;
    logic [29:0]       aluIdx;
    logic              unusedPcBits;
    logic              dmemInRange;
    logic              storeReq;
    logic              storeAligned;
    logic              dmemWe;
    logic              misalignErr_q, misalignErr_d;

    mips_boot_loader #(
        .IMEM_WORDS(IMEM_WORDS)
    ) u_loader (
        .clk_i      (CLK),
        .rst_i      (Reset),
        .ldValid_i  (ld_valid),
        .ldByte_i   (ld_byte),
        .ldReady_o  (ld_ready),
        .cpuReset_o (cpuReset),
        .loadDone_o (load_done),
        .loadError_o(load_error),
        .loadedCnt_o(loadedCnt),
        .imemWe_o   (imemWe),
        .imemAddr_o (imemAddr),
        .imemData_o (imemData)
    );

    assign cpu_reset    = cpuReset;
    assign pcIdx        = Pc[31:2];
    assign aluIdx       = ALU_out[31:2];
    assign unusedPcBits = ^Pc[1:0];
    assign dmemInRange  = (aluIdx < 30'(DMEM_WORDS));
    assign storeReq     = mem_write && !cpuReset;
    assign storeAligned = (ALU_out[1:0] == 2'b00);
    assign dmemWe       = storeReq && storeAligned && dmemInRange;

    // Gating on loadedCnt keeps stale words from an earlier load invisible.
    always_comb begin
        Instr = NOP_INSTR;
        if (!cpuReset && (pcIdx < {14'b0, loadedCnt})) begin
            Instr = imem[pcIdx[IA-1:0]];
        end
    end

    always_comb begin
        Read_Data = NOP_INSTR;
        if (dmemInRange) begin
            Read_Data = dmem[aluIdx[DA-1:0]];
        end
    end

    always_ff @(posedge CLK) begin
        if (imemWe) begin
            imem[imemAddr] <= imemData;
        end
    end

    always_ff @(posedge CLK) begin
        if (dmemWe) begin
            dmem[aluIdx[DA-1:0]] <= Write_Data;
        end
    end

    assign misalignErr_d = misalignErr_q || (storeReq && !storeAligned);
    assign misalign_err  = misalignErr_q;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            misalignErr_q <= 1'b0;
        end else begin
            misalignErr_q <= misalignErr_d;
        end
    end

endmodule

// File: tb/tb_mips_mem_subsystem.sv
// Directed bench for mips_mem_subsystem: loader sequences by hand, core accesses from a vector table.
module tb_mips_mem_subsystem;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] Pc;
    logic [31:0] Instr;
    logic [31:0] ALU_out;
    logic        mem_write;
    logic [31:0] Write_Data;
    logic [31:0] Read_Data;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_ready;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] aluOut;
        logic        memWrite;
        logic [31:0] writeData;
        logic [31:0] pc;
        logic        chkRead;
        logic [31:0] expRead;
        logic [31:0] expInstr;
        logic        expMisalign;
    } runVec_t;

    runVec_t    vecs [11];
    logic [7:0] loadN2 [10];
    logic [7:0] loadN1 [6];
    logic [7:0] partial [5];

    always #5 CLK = ~CLK;

    mips_mem_subsystem #(
        .IMEM_WORDS(64),
        .DMEM_WORDS(64)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .Pc          (Pc),
        .Instr       (Instr),
        .ALU_out     (ALU_out),
        .mem_write   (mem_write),
        .Write_Data  (Write_Data),
        .Read_Data   (Read_Data),
        .ld_valid    (ld_valid),
        .ld_byte     (ld_byte),
        .ld_ready    (ld_ready),
        .cpu_reset   (cpu_reset),
        .load_done   (load_done),
        .load_error  (load_error),
        .misalign_err(misalign_err)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkFlags(input string name, input logic expReady, input logic expCpuRst,
                              input logic expDone, input logic expErr);
        checkOutput({name, " ld_ready"},   {31'b0, ld_ready},   {31'b0, expReady});
        checkOutput({name, " cpu_reset"},  {31'b0, cpu_reset},  {31'b0, expCpuRst});
        checkOutput({name, " load_done"},  {31'b0, load_done},  {31'b0, expDone});
        checkOutput({name, " load_error"}, {31'b0, load_error}, {31'b0, expErr});
    endtask

    task automatic checkInstrAt(input string name, input logic [31:0] pc, input logic [31:0] exp);
        Pc = pc;
        #1;
        checkOutput(name, Instr, exp);
    endtask

    // Called at a falling edge; returns at the next falling edge after the byte is offered.
    task automatic sendByte(input logic [7:0] b);
        ld_valid = 1'b1;
        ld_byte  = b;
        @(negedge CLK);
        ld_valid = 1'b0;
    endtask

    task automatic pulseReset();
        @(negedge CLK);
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
    endtask

    task automatic applyStimulus(input runVec_t v);
        ALU_out    = v.aluOut;
        mem_write  = v.memWrite;
        Write_Data = v.writeData;
        Pc         = v.pc;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        loadN2  = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h04};
        loadN1  = '{8'h00, 8'h01, 8'h8C, 8'h09, 8'h00, 8'h20};
        partial = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33};

        vecs[0]  = '{32'h10,  1'b1, 32'hDEADBEEF, 32'h0,   1'b0, 32'h0,        32'h20080005, 1'b0};
        vecs[1]  = '{32'h10,  1'b0, 32'h0,        32'h4,   1'b1, 32'hDEADBEEF, 32'hAC080004, 1'b0};
        vecs[2]  = '{32'h12,  1'b1, 32'h12345678, 32'h8,   1'b1, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[3]  = '{32'h10,  1'b0, 32'h0,        32'h5,   1'b1, 32'hDEADBEEF, 32'hAC080004, 1'b1};
        vecs[4]  = '{32'h14,  1'b1, 32'hA5A5A5A5, 32'h100, 1'b0, 32'h0,        32'h0,        1'b1};
        vecs[5]  = '{32'h17,  1'b0, 32'h0,        32'hFC,  1'b1, 32'hA5A5A5A5, 32'h0,        1'b1};
        vecs[6]  = '{32'h00,  1'b1, 32'h01020304, 32'h0,   1'b0, 32'h0,        32'h20080005, 1'b1};
        vecs[7]  = '{32'h100, 1'b1, 32'hFFFFFFFF, 32'h4,   1'b1, 32'h0,        32'hAC080004, 1'b1};
        vecs[8]  = '{32'h00,  1'b0, 32'h0,        32'h3,   1'b1, 32'h01020304, 32'h20080005, 1'b1};
        vecs[9]  = '{32'h20,  1'b1, 32'hCAFEF00D, 32'h0,   1'b0, 32'h0,        32'h20080005, 1'b1};
        vecs[10] = '{32'h20,  1'b0, 32'h0,        32'h4,   1'b1, 32'hCAFEF00D, 32'hAC080004, 1'b1};

        Reset      = 1'b1;
        Pc         = 32'h0;
        ALU_out    = 32'h0;
        mem_write  = 1'b0;
        Write_Data = 32'h0;
        ld_valid   = 1'b0;
        ld_byte    = 8'h00;

        #2;
        checkFlags("reset", 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("reset misalign_err", {31'b0, misalign_err}, 32'h0);
        checkOutput("reset Instr", Instr, 32'h0);
        @(negedge CLK);
        Reset = 1'b0;

        // Normal two-word load
        for (int i = 0; i < 10; i++) begin
            if (i == 9) checkFlags("n2 before last byte", 1'b1, 1'b1, 1'b0, 1'b0);
            sendByte(loadN2[i]);
            if (i == 5) checkOutput("n2 Instr hidden during load", Instr, 32'h0);
        end
        checkFlags("n2 run", 1'b0, 1'b0, 1'b1, 1'b0);
        checkInstrAt("n2 Instr pc0", 32'h0, 32'h20080005);
        checkInstrAt("n2 Instr pc4", 32'h4, 32'hAC080004);
        checkInstrAt("n2 Instr pc8", 32'h8, 32'h0);

        // Core-side loads and stores in RUN
        for (int i = 0; i < 11; i++) begin
            @(negedge CLK);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d Instr", i), Instr, vecs[i].expInstr);
            if (vecs[i].chkRead) checkOutput($sformatf("vec%0d Read_Data", i), Read_Data, vecs[i].expRead);
            checkOutput($sformatf("vec%0d misalign_err", i), {31'b0, misalign_err}, {31'b0, vecs[i].expMisalign});
        end
        @(negedge CLK);
        mem_write = 1'b0;

        // Zero-length image
        pulseReset();
        checkOutput("n0 misalign cleared", {31'b0, misalign_err}, 32'h0);
        sendByte(8'h00);
        sendByte(8'h00);
        checkFlags("n0 run", 1'b0, 1'b0, 1'b1, 1'b0);
        checkInstrAt("n0 Instr pc0", 32'h0, 32'h0);
        checkInstrAt("n0 Instr pc4", 32'h4, 32'h0);

        // Oversized image
        pulseReset();
        @(negedge CLK);
        sendByte(8'h00);
        sendByte(8'h41);
        checkFlags("n65 error", 1'b0, 1'b1, 1'b0, 1'b1);
        sendByte(8'h00);
        checkFlags("n65 stays error", 1'b0, 1'b1, 1'b0, 1'b1);
        checkInstrAt("n65 Instr pc0", 32'h0, 32'h0);

        // Reset mid-load with gaps, stores attempted throughout the reload
        pulseReset();
        ALU_out    = 32'h20;
        Write_Data = 32'h99999999;
        mem_write  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sendByte(partial[i]);
            @(negedge CLK);
        end
        checkFlags("partial loading", 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        Reset = 1'b1;
        #1;
        checkFlags("midload reset", 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("midload misalign_err", {31'b0, misalign_err}, 32'h0);
        checkInstrAt("midload Instr", 32'h0, 32'h0);
        @(negedge CLK);
        Reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sendByte(loadN1[i]);
        end
        mem_write = 1'b0;
        checkFlags("reload run", 1'b0, 1'b0, 1'b1, 1'b0);
        checkInstrAt("reload Instr pc0", 32'h0, 32'h8C090020);
        checkInstrAt("reload Instr pc4", 32'h4, 32'h0);
        ALU_out = 32'h20;
        #1;
        checkOutput("dmem untouched by load-time store", Read_Data, 32'hCAFEF00D);
        checkOutput("reload misalign_err", {31'b0, misalign_err}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
